// File: rtl/rf_pkg.sv
// ----------------------------------------------------------------------------
// rf_pkg
// Shared constants for the multi-port register file and its busy scoreboard.
//   RF_DATA_W   : default register width
//   RF_ADDR_W   : default address width (DEPTH = 2**RF_ADDR_W)
//   RF_NUM_READ : default number of combinational read ports
//   ZERO_IDX    : index of the hardwired-zero register
// ----------------------------------------------------------------------------
package rf_pkg;

    localparam int RF_DATA_W   = 32;
    localparam int RF_ADDR_W   = 5;
    localparam int RF_NUM_READ = 2;
    localparam int ZERO_IDX    = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// ----------------------------------------------------------------------------
// regfile_scoreboard
// Per-register busy bits plus a registered count of busy registers.
// Decode marks a destination busy (set); writeback clears it (clr).
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   set_en/addr   : allocate a destination (busy := 1)
//   clr_en/addr   : writeback completion (busy := 0)
//   busy_vec      : current busy bit per register
//   busy_count    : number of busy registers
// ----------------------------------------------------------------------------
module regfile_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  set_en,
    input  logic [ADDR_W-1:0]     set_addr,
    input  logic                  clr_en,
    input  logic [ADDR_W-1:0]     clr_addr,
    output logic [(1<<ADDR_W)-1:0] busy_vec,
    output logic [ADDR_W:0]       busy_count
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [ADDR_W:0]  count_q, count_d;
    logic             set_eff, clr_eff;
    logic             inc, dec;

    always_comb begin
        set_eff = set_en && !((ZERO_REG != 0) && (set_addr == ADDR_W'(ZERO_IDX)));
        clr_eff = clr_en && !((ZERO_REG != 0) && (clr_addr == ADDR_W'(ZERO_IDX)));

        busy_d = busy_q;
        // Clear first, then set: a same-cycle alloc on the written register
        // represents a newer producer and must leave the register busy.
        if (clr_eff) busy_d[clr_addr] = 1'b0;
        if (set_eff) busy_d[set_addr] = 1'b1;

        // Count only real transitions; when set and clear hit the same
        // register the clear never takes effect, so dec stays 0.
        inc = set_eff && !busy_q[set_addr] && busy_d[set_addr];
        dec = clr_eff && busy_q[clr_addr] && !busy_d[clr_addr];

        count_d = count_q + {{ADDR_W{1'b0}}, inc} - {{ADDR_W{1'b0}}, dec};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy_vec   = busy_q;
    assign busy_count = count_q;

endmodule

// File: rtl/register_file_mp.sv
// ----------------------------------------------------------------------------
// register_file_mp
// Register file with NUM_READ combinational read ports, one synchronous write
// port, optional write-to-read bypass, optional hardwired-zero register 0 and
// a per-register busy scoreboard for RAW hazard detection.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   read_addr  [NUM_READ*ADDR_W]: packed read addresses (port i at i*ADDR_W)
//   read_data  [NUM_READ*DATA_W]: packed read data (port i at i*DATA_W)
//   read_busy  [NUM_READ]       : addressed register has a pending producer
//   write_enable/address/data   : writeback port (also clears busy)
//   alloc_enable/address        : decode allocation (sets busy)
//   busy_count [ADDR_W+1]       : number of busy registers
// ----------------------------------------------------------------------------
module register_file_mp
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_READ = RF_NUM_READ,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_READ*ADDR_W-1:0]   read_addr,
    output logic [NUM_READ*DATA_W-1:0]   read_data,
    output logic [NUM_READ-1:0]          read_busy,
    input  logic                         write_enable,
    input  logic [ADDR_W-1:0]            write_address,
    input  logic [DATA_W-1:0]            write_data,
    input  logic                         alloc_enable,
    input  logic [ADDR_W-1:0]            alloc_address,
    output logic [ADDR_W:0]              busy_count
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_vec;
    logic              write_eff;

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .set_en     (alloc_enable),
        .set_addr   (alloc_address),
        .clr_en     (write_enable),
        .clr_addr   (write_address),
        .busy_vec   (busy_vec),
        .busy_count (busy_count)
    );

    always_comb begin
        write_eff = write_enable &&
                    !((ZERO_REG != 0) && (write_address == ADDR_W'(ZERO_IDX)));
        regs_d = regs_q;
        if (write_eff) regs_d[write_address] = write_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_read
        logic [ADDR_W-1:0] ra;
        logic              zero_hit;
        logic              byp_hit;

        assign ra       = read_addr[i*ADDR_W +: ADDR_W];
        assign zero_hit = (ZERO_REG != 0) && (ra == ADDR_W'(ZERO_IDX));
        // Forwarded data is the producer's result, so the register is no
        // longer pending; a same-cycle alloc only shows up next cycle.
        assign byp_hit  = (BYPASS != 0) && write_enable && (write_address == ra);

        assign read_data[i*DATA_W +: DATA_W] = zero_hit ? '0 :
                                               byp_hit  ? write_data :
                                                          regs_q[ra];
        assign read_busy[i] = zero_hit ? 1'b0 :
                              byp_hit  ? 1'b0 :
                                         busy_vec[ra];
    end

endmodule

// File: tb/tb_register_file_mp.sv
module tb_register_file_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [NR*AW-1:0] read_addr;
    logic [NR*DW-1:0] rd_byp, rd_nb;
    logic [NR-1:0] busy_byp, busy_nb;
    logic          write_enable;
    logic [AW-1:0] write_address;
    logic [DW-1:0] write_data;
    logic          alloc_enable;
    logic [AW-1:0] alloc_address;
    logic [AW:0]   cnt_byp, cnt_nb;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          step;
        logic [31:0] d0, d1;
        logic [1:0]  b;
        logic [5:0]  c;
        logic [31:0] n0, n1;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    register_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR),
                       .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .read_addr(read_addr),
        .read_data(rd_byp), .read_busy(busy_byp),
        .write_enable(write_enable), .write_address(write_address),
        .write_data(write_data), .alloc_enable(alloc_enable),
        .alloc_address(alloc_address), .busy_count(cnt_byp)
    );

    register_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR),
                       .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .read_addr(read_addr),
        .read_data(rd_nb), .read_busy(busy_nb),
        .write_enable(write_enable), .write_address(write_address),
        .write_data(write_data), .alloc_enable(alloc_enable),
        .alloc_address(alloc_address), .busy_count(cnt_nb)
    );

    task automatic chk(input int step, input string what,
                       input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL step%0d_%s actual=%h required=%h", step, what, act, req);
        end
    endtask

    // Monitor: outputs are combinational, so compare on the falling edge of
    // every cycle for which stimulus queued an expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.step, "d0",    64'(rd_byp[31:0]),  64'(e.d0));
            chk(e.step, "d1",    64'(rd_byp[63:32]), 64'(e.d1));
            chk(e.step, "busy",  64'(busy_byp),      64'(e.b));
            chk(e.step, "cnt",   64'(cnt_byp),       64'(e.c));
            chk(e.step, "nb_d0", 64'(rd_nb[31:0]),   64'(e.n0));
            chk(e.step, "nb_d1", 64'(rd_nb[63:32]),  64'(e.n1));
            chk(e.step, "nb_cnt", 64'(cnt_nb),       64'(e.c));
        end
    end

    task automatic drive(input logic rst, input logic we, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic ae,
                         input logic [AW-1:0] aa, input logic [AW-1:0] a0,
                         input logic [AW-1:0] a1);
        reset         = rst;
        write_enable  = we;
        write_address = wa;
        write_data    = wd;
        alloc_enable  = ae;
        alloc_address = aa;
        read_addr     = {a1, a0};
    endtask

    task automatic expect_v(input int step, input logic [31:0] d0, input logic [31:0] d1,
                            input logic [1:0] b, input logic [5:0] c,
                            input logic [31:0] n0, input logic [31:0] n1);
        exp_t e;
        e.step = step; e.d0 = d0; e.d1 = d1; e.b = b; e.c = c; e.n0 = n0; e.n1 = n1;
        exp_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        // Reset state
        drive(0, 0, 0, 0, 0, 0, 1, 2);
        expect_v(1, 0, 0, 2'b00, 0, 0, 0);
        next_cycle();
        // Write reg15 = 0xC: bypass shows it now, non-bypass shows old 0
        drive(0, 1, 15, 32'h0000_000C, 0, 0, 1, 15);
        expect_v(2, 0, 32'hC, 2'b00, 0, 0, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 1, 15);
        expect_v(3, 0, 32'hC, 2'b00, 0, 0, 32'hC);
        next_cycle();
        // Zero register: write and alloc of reg0 are ignored
        drive(0, 1, 0, 32'hFFFF_FFFF, 1, 0, 0, 0);
        expect_v(4, 0, 0, 2'b00, 0, 0, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        expect_v(5, 0, 0, 2'b00, 0, 0, 0);
        next_cycle();
        // Alloc reg5: visible next cycle
        drive(0, 0, 0, 0, 1, 5, 5, 7);
        expect_v(6, 0, 0, 2'b00, 0, 0, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 5, 7);
        expect_v(7, 0, 0, 2'b01, 1, 0, 0);
        next_cycle();
        // Alloc reg7 while writing reg5 = 0xA5: net count change 0
        drive(0, 1, 5, 32'h0000_00A5, 1, 7, 5, 7);
        expect_v(8, 32'hA5, 0, 2'b00, 1, 0, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 5, 7);
        expect_v(9, 32'hA5, 0, 2'b10, 1, 32'hA5, 0);
        next_cycle();
        // Alloc and write reg7 together: new producer wins, stays busy
        drive(0, 1, 7, 32'h0000_0077, 1, 7, 5, 7);
        expect_v(10, 32'hA5, 32'h77, 2'b00, 1, 32'hA5, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 5, 7);
        expect_v(11, 32'hA5, 32'h77, 2'b10, 1, 32'hA5, 32'h77);
        next_cycle();
        // Write reg7 (clears busy) while allocating reg3
        drive(0, 1, 7, 32'h0000_0070, 1, 3, 3, 7);
        expect_v(12, 0, 32'h70, 2'b00, 1, 0, 32'h77);
        next_cycle();
        drive(0, 0, 0, 0, 1, 4, 3, 7);
        expect_v(13, 0, 32'h70, 2'b01, 1, 0, 32'h70);
        next_cycle();
        drive(0, 0, 0, 0, 1, 6, 4, 6);
        expect_v(14, 0, 0, 2'b01, 2, 0, 0);
        next_cycle();
        // Re-alloc of busy reg6: count unchanged
        drive(0, 0, 0, 0, 1, 6, 3, 6);
        expect_v(15, 0, 0, 2'b11, 3, 0, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 3, 6);
        expect_v(16, 0, 0, 2'b11, 3, 0, 0);
        next_cycle();
        // Reset with a concurrent write and alloc: reset wins
        drive(1, 1, 3, 32'h0000_0033, 1, 4, 3, 6);
        expect_v(17, 32'h33, 0, 2'b10, 3, 0, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 3, 15);
        expect_v(18, 0, 0, 2'b00, 0, 0, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 4, 5);
        expect_v(19, 0, 0, 2'b00, 0, 0, 0);
        next_cycle();
        next_cycle();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
